// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, defaults and helpers for the regfile_sb register file
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    function automatic int addr_width(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with set-over-clear priority and two lookups
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = addr_width(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1addr,
    input  logic [AW-1:0] rs2addr,
    output logic          rs1_busy,
    output logic          rs2_busy
);

    // Register 0 has no busy bit: it never has a pending producer.
    logic [NREGS-1:1] busy_q;

    // A new issue to a register wins over a writeback that retires the old producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (set_en && set_addr == AW'(i)) begin
                    busy_q[i] <= 1'b1;
                end else if (clr_en && clr_addr == AW'(i)) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // Pre-edge busy lookups for both read ports.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (rs1addr != '0) rs1_busy = busy_q[rs1addr];
        if (rs2addr != '0) rs2_busy = busy_q[rs2addr];
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 2R1W register file with busy scoreboard and post-reset clear; REGFILE_BYPASS_EN enables write-to-read bypass
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = addr_width(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1addr,
    input  logic [AW-1:0]   rs2addr,
    output logic [XLEN-1:0] rs1o,
    output logic [XLEN-1:0] rs2o,
    input  logic            rs1_use,
    input  logic            rs2_use,
    input  logic            issue,
    input  logic [AW-1:0]   issue_rd,
    input  logic            regwr,
    input  logic [AW-1:0]   rdaddr,
    input  logic [XLEN-1:0] win,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            hazard,
    output logic            ready
);

    // Register 0 is hardwired to zero, so no storage exists for it.
    logic [XLEN-1:0] regs [1:NREGS-1];

    state_t        state, state_next;
    logic [AW-1:0] clr_ptr, clr_ptr_next;

    logic          run;
    logic          wr_en;
    logic          set_en;
    logic [XLEN-1:0] rd1_arr, rd2_arr;
    logic          sb1_busy, sb2_busy;

    assign run    = (state == RUN);
    assign wr_en  = run && regwr && (rdaddr != '0);
    assign set_en = run && issue && (issue_rd != '0);
    assign ready  = run;

    // Clear FSM state register; reset restarts the sweep at register 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= AW'(1);
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    // Sweep registers 1..NREGS-1, entering RUN on the edge that zeroes the last one.
    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        case (state)
            CLEAR: begin
                clr_ptr_next = clr_ptr + AW'(1);
                if (clr_ptr == AW'(NREGS - 1)) state_next = RUN;
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Array write: zeroing sweep during CLEAR, writeback during RUN.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            regs[clr_ptr] <= '0;
        end else if (wr_en) begin
            regs[rdaddr] <= win;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (set_en),
        .set_addr (issue_rd),
        .clr_en   (wr_en),
        .clr_addr (rdaddr),
        .rs1addr  (rs1addr),
        .rs2addr  (rs2addr),
        .rs1_busy (sb1_busy),
        .rs2_busy (sb2_busy)
    );

    // Raw array reads with register 0 reading as zero.
    always_comb begin
        rd1_arr = '0;
        rd2_arr = '0;
        if (rs1addr != '0) rd1_arr = regs[rs1addr];
        if (rs2addr != '0) rd2_arr = regs[rs2addr];
    end

    // Output muxing: everything is held at zero until the clear sweep completes.
    always_comb begin
        rs1o     = '0;
        rs2o     = '0;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (run) begin
            rs1o     = rd1_arr;
            rs2o     = rd2_arr;
            rs1_busy = sb1_busy;
            rs2_busy = sb2_busy;
`ifdef REGFILE_BYPASS_EN
            // Forward same-cycle writeback; busy shows its post-edge value.
            if (wr_en && rdaddr == rs1addr) begin
                rs1o     = win;
                rs1_busy = set_en && (issue_rd == rdaddr);
            end
            if (wr_en && rdaddr == rs2addr) begin
                rs2o     = win;
                rs2_busy = set_en && (issue_rd == rdaddr);
            end
`endif
        end
        hazard = (rs1_use && rs1_busy) || (rs2_use && rs2_busy);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard-checked directed bench for regfile_sb
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int S_RS1O = 0, S_RS2O = 1, S_RS1B = 2, S_RS2B = 3, S_HAZ = 4, S_RDY = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   rs1addr = '0, rs2addr = '0, issue_rd = '0, rdaddr = '0;
    logic [XLEN-1:0] rs1o, rs2o, win = '0;
    logic            rs1_use = 1'b0, rs2_use = 1'b0, issue = 1'b0, regwr = 1'b0;
    logic            rs1_busy, rs2_busy, hazard, ready;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1addr  (rs1addr),
        .rs2addr  (rs2addr),
        .rs1o     (rs1o),
        .rs2o     (rs2o),
        .rs1_use  (rs1_use),
        .rs2_use  (rs2_use),
        .issue    (issue),
        .issue_rd (issue_rd),
        .regwr    (regwr),
        .rdaddr   (rdaddr),
        .win      (win),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .hazard   (hazard),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sample(input int sig);
        case (sig)
            S_RS1O:  return rs1o;
            S_RS2O:  return rs2o;
            S_RS1B:  return {31'd0, rs1_busy};
            S_RS2B:  return {31'd0, rs2_busy};
            S_HAZ:   return {31'd0, hazard};
            default: return {31'd0, ready};
        endcase
    endfunction

    task automatic expect_sig(input int sig, input logic [31:0] v, input string nm);
        q.push_back('{cyc, sig, v, nm});
    endtask

    // Monitor: compare every expectation queued for this cycle, away from the edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            logic [31:0] act;
            e = q.pop_front();
            act = sample(e.sig);
            total++;
            if (act === e.exp) passed++;
            else $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, e.cyc);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_phase;
        rst_n = 1'b0;
        step();
        expect_sig(S_RS1O, 0, "rst_rs1o");
        expect_sig(S_RS2O, 0, "rst_rs2o");
        expect_sig(S_RS1B, 0, "rst_rs1_busy");
        expect_sig(S_RS2B, 0, "rst_rs2_busy");
        expect_sig(S_HAZ, 0, "rst_hazard");
        expect_sig(S_RDY, 0, "rst_ready");
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            step();
            if (k == 6) begin
                regwr = 1'b1; rdaddr = 5; win = 32'hDEADBEEF;
                issue = 1'b1; issue_rd = 5;
                rs1addr = 5; rs1_use = 1'b1;
            end
            if (k == 31) begin
                regwr = 1'b0; issue = 1'b0;
            end
            expect_sig(S_RDY, (k == 31) ? 1 : 0, "clear_ready");
            if (k > 6 && k < 31) expect_sig(S_HAZ, 0, "clear_hazard");
        end
        step();
        expect_sig(S_RS1O, 0, "clear_r5_ignored_wr");
        expect_sig(S_RS1B, 0, "clear_r5_ignored_issue");
        rs1_use = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            rs1addr = AW'(i);
            rs2addr = AW'(i + 16);
            expect_sig(S_RS1O, 0, "clear_zero_lo");
            expect_sig(S_RS2O, 0, "clear_zero_hi");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rs1addr = 3;
        clear_phase();

        // basic write/read and register 0
        step(); regwr = 1; rdaddr = 7; win = 32'h12345678; rs1addr = 7;
        expect_sig(S_RS1O, BYP ? 32'h12345678 : 32'h0, "wr_same_cycle_r7");
        step(); regwr = 0;
        expect_sig(S_RS1O, 32'h12345678, "rd_r7");
        step(); regwr = 1; rdaddr = 0; win = 32'hFFFFFFFF; rs2addr = 0;
        expect_sig(S_RS2O, 0, "wr_r0_same");
        step(); regwr = 0;
        expect_sig(S_RS2O, 0, "rd_r0");

        // scoreboard set and clear
        step(); issue = 1; issue_rd = 3; rs1addr = 3; rs1_use = 1;
        expect_sig(S_RS1B, 0, "issue_r3_preedge");
        step(); issue = 0;
        expect_sig(S_RS1B, 1, "busy_r3");
        expect_sig(S_HAZ, 1, "hazard_r3");
        step(); regwr = 1; rdaddr = 3; win = 32'hA5;
        expect_sig(S_RS1B, BYP ? 0 : 1, "wb_r3_busy");
        expect_sig(S_HAZ, BYP ? 0 : 1, "wb_r3_hazard");
        expect_sig(S_RS1O, BYP ? 32'hA5 : 32'h0, "wb_r3_data");
        step(); regwr = 0;
        expect_sig(S_RS1B, 0, "r3_cleared");
        expect_sig(S_HAZ, 0, "r3_no_hazard");
        expect_sig(S_RS1O, 32'hA5, "rd_r3");

        // set/clear collision on r4
        step(); rs1_use = 0; issue = 1; issue_rd = 4; regwr = 1; rdaddr = 4; win = 32'h11;
        rs2addr = 4; rs2_use = 1;
        expect_sig(S_RS2O, BYP ? 32'h11 : 32'h0, "coll_data_same");
        expect_sig(S_RS2B, BYP ? 1 : 0, "coll_busy_same");
        step(); issue = 0; regwr = 0;
        expect_sig(S_RS2B, 1, "coll_busy");
        expect_sig(S_RS2O, 32'h11, "coll_data");
        expect_sig(S_HAZ, 1, "coll_hazard");

        // bypass case on r9
        step(); rs2_use = 0; regwr = 1; rdaddr = 9; win = 32'hCAFE; rs1addr = 9;
        expect_sig(S_RS1O, BYP ? 32'hCAFE : 32'h0, "byp_r9_data");
        expect_sig(S_RS1B, 0, "byp_r9_busy");
        step(); regwr = 0;
        expect_sig(S_RS1O, 32'hCAFE, "rd_r9");

        // issue to r0 has no effect
        step(); issue = 1; issue_rd = 0; rs1addr = 0; rs1_use = 1;
        step(); issue = 0;
        expect_sig(S_RS1B, 0, "r0_never_busy");
        expect_sig(S_HAZ, 0, "r0_no_hazard");

        // reset mid-run
        step(); issue = 1; issue_rd = 2;
        step(); issue_rd = 6;
        step(); issue = 0; rs1addr = 2; rs2addr = 6; rs1_use = 1; rs2_use = 1;
        expect_sig(S_RS1B, 1, "busy_r2");
        expect_sig(S_RS2B, 1, "busy_r6");
        expect_sig(S_HAZ, 1, "hazard_r2_r6");
        expect_sig(S_RDY, 1, "ready_run");
        step(); rst_n = 0;
        expect_sig(S_RS1B, 0, "midrst_busy_r2");
        expect_sig(S_RS2B, 0, "midrst_busy_r6");
        expect_sig(S_HAZ, 0, "midrst_hazard");
        expect_sig(S_RDY, 0, "midrst_ready");
        rs2_use = 0;
        clear_phase();
        step(); rs1addr = 7; rs2addr = 4;
        expect_sig(S_RS1O, 0, "reclear_r7");
        expect_sig(S_RS2O, 0, "reclear_r4");
        expect_sig(S_RS2B, 0, "reclear_busy_r4");

        step();
        step();
        if (q.size() != 0) begin
            total++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
